fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  16  byte address of the requested instruction; bit 0 always 0.
REQ-006 SHALL have port imem_rdy  input  1  imem_data valid this cycle for the outstanding request; latency 1..N cycles.
REQ-007 SHALL have port imem_data  input  16  fetched instruction word.
REQ-008 SHALL have port stall  input  1  decode cannot accept a new instruction; IF/ID holds.
REQ-009 SHALL have port redirect_valid  input  1  taken branch or jump resolved downstream; flushes IF/ID.
REQ-010 SHALL have port redirect_target  input  16  new PC; bit 0 ignored and forced to 0.
REQ-011 SHALL have port ifid_valid  output  1  IF/ID register holds a live instruction.
REQ-012 SHALL have port ifid_instr  output  16  IF/ID instruction; bits [15:12] drive the control decoder opcode.
REQ-013 SHALL have port ifid_pc_plus2  output  16  address of the IF/ID instruction plus 2, modulo 2^16.
REQ-014 SHALL have port halted  output  1  fetch stopped on a halt opcode (4'b1111).

Function
REQ-015 SHALL implement states FETCH, HOLD, DISCARD, and HALTED.
REQ-016 In FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_rdy.
REQ-017 FETCH with imem_rdy, !stall, !redirect_valid: IF/ID loads {1, imem_data, pc+2} next edge; pc<=pc+2; remain FETCH. Result: one instruction per cycle with zero-wait memory.
REQ-018 FETCH with imem_rdy, stall, !redirect_valid: imem_data captured in one-entry skid buffer; pc unchanged; go HOLD; IF/ID unchanged.
REQ-019 In HOLD: imem_req=0; when stall deasserts, skid moves into IF/ID, pc<=pc+2, return to FETCH.
REQ-020 An instruction entering IF/ID with opcode 4'b1111: pc SHALL NOT advance; state goes to HALTED; the instruction itself SHALL still be delivered with ifid_valid=1.
REQ-021 In HALTED: imem_req=0, halted=1, pc and IF/ID hold unless stall=0; once decode accepts, ifid_valid<=0.
REQ-022 redirect_valid has priority over stall and over any memory response: ifid_valid<=0, skid cleared, pc<=redirect_target & 16'hFFFE.
REQ-023 Redirect while in FETCH with imem_rdy=0: go DISCARD; imem_req stays 1 with the old address until imem_rdy; that response is dropped; then FETCH at the new pc.
REQ-024 Redirect in the same cycle as imem_rdy: data dropped; FETCH at target next cycle.
REQ-025 Redirect in HOLD or HALTED: go FETCH at target; halted<=0.
REQ-026 Redirect during DISCARD: pc updated to the newest target; remain DISCARD until the outstanding response arrives.
REQ-027 pc+2 SHALL wrap 16'hFFFE -> 16'h0000 without error.
REQ-028 imem_rdy while imem_req=0 SHALL be ignored.

Reset
REQ-029 On rst: pc=RESET_PC, state=FETCH, ifid_valid=0, ifid_instr=16'h0000, ifid_pc_plus2=16'h0000, skid empty, halted=0.
REQ-030 imem_req SHALL be 0 while rst is high and SHALL assert from the first edge after release.
REQ-031 Reset asserted mid-request SHALL abandon the request; no memory response is consumed afterward until a new request is issued.

Structure
REQ-032 A shared package SHALL hold the fetch state enum, the HALT_OPCODE constant 4'b1111, and the instruction/address width constant 16.
REQ-033 The one-entry skid buffer SHALL be a sub-module fetch_skid: load, clear, valid, and data.

Verification
REQ-034 Zero-wait memory, program at 0x0000..0x0006, no stall -> ifid_pc_plus2 sequence 2,4,6,8 on consecutive cycles, ifid_valid steady 1.
REQ-035 3-cycle memory latency -> imem_addr stable for 3 cycles per fetch; one IF/ID load per response.
REQ-036 stall high for 4 cycles while a response arrives -> IF/ID unchanged, imem_req=0 in HOLD, skid instruction appears the cycle after stall drops, no instruction lost or duplicated.
REQ-037 redirect_target=0x0041 while a 2-cycle request to 0x0010 is outstanding -> ifid_valid=0, stale data dropped, next imem_addr=0x0040.
REQ-038 Fetch of 0xF000 at 0x0008 -> IF/ID holds 0xF000, halted=1, imem_req=0 thereafter; a later redirect to 0x0020 resumes fetch at 0x0020 with halted=0.
REQ-039 pc=0xFFFE -> next imem_addr=0x0000; rst pulsed mid-request -> all outputs reach their reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared widths, halt opcode and fetch state encoding.
package fetch_stage_pkg;
  localparam int XLEN = 16;
  localparam logic [3:0] HALT_OPCODE = 4'b1111;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD, HALTED} fetch_state_e;
  function automatic logic is_halt(input logic [XLEN-1:0] instr);
    return instr[XLEN-1 -: 4] == HALT_OPCODE;
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer holding a response that arrived while decode stalled.
module fetch_skid
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] data_i,
  output logic            valid_o,
  output logic [XLEN-1:0] data_o
);
  logic            valid_q;
  logic [XLEN-1:0] data_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch with skid buffering, redirect flush and halt detection.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rdy,
  input  logic [XLEN-1:0] imem_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            ifid_valid,
  output logic [XLEN-1:0] ifid_instr,
  output logic [XLEN-1:0] ifid_pc_plus2,
  output logic            halted
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, disc_addr_q, disc_addr_d;
  logic [XLEN-1:0] ifid_instr_q, ifid_instr_d, ifid_pc2_q, ifid_pc2_d;
  logic            ifid_valid_q, ifid_valid_d, req_en_q;
  logic            rsp, deliver_skid, deliver_mem, skid_load, skid_valid;
  logic [XLEN-1:0] skid_data, new_instr, pc_plus2;
  // req_en_q keeps the request low until the first edge after reset release
  assign imem_req     = req_en_q && (state_q == FETCH || state_q == DISCARD);
  assign imem_addr    = state_q == DISCARD ? disc_addr_q : pc_q;
  assign rsp          = imem_req && imem_rdy;
  assign pc_plus2     = pc_q + 16'd2;
  assign deliver_skid = state_q == HOLD && skid_valid && !stall && !redirect_valid;
  assign deliver_mem  = state_q == FETCH && rsp && !stall && !redirect_valid;
  assign skid_load    = state_q == FETCH && rsp && stall && !redirect_valid;
  assign new_instr    = deliver_skid ? skid_data : imem_data;
  fetch_skid u_skid (
    .clk    (clk),
    .rst    (rst),
    .load_i (skid_load),
    .clear_i(redirect_valid || deliver_skid),
    .data_i (imem_data),
    .valid_o(skid_valid),
    .data_o (skid_data)
  );
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    disc_addr_d  = disc_addr_q;
    ifid_valid_d = stall ? ifid_valid_q : 1'b0;
    ifid_instr_d = ifid_instr_q;
    ifid_pc2_d   = ifid_pc2_q;
    if (redirect_valid) begin
      pc_d         = redirect_target & 16'hFFFE;
      ifid_valid_d = 1'b0;
      state_d      = (imem_req && !imem_rdy) ? DISCARD : FETCH;
      disc_addr_d  = state_q == DISCARD ? disc_addr_q : pc_q;
    end else if (deliver_skid || deliver_mem) begin
      ifid_valid_d = 1'b1;
      ifid_instr_d = new_instr;
      ifid_pc2_d   = pc_plus2;
      state_d      = is_halt(new_instr) ? HALTED : FETCH;
      pc_d         = is_halt(new_instr) ? pc_q : pc_plus2;
    end else if (skid_load) begin
      state_d = HOLD;
    end else if (state_q == DISCARD && rsp) begin
      state_d = FETCH;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC & 16'hFFFE;
      disc_addr_q  <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= '0;
      ifid_pc2_q   <= '0;
      req_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      disc_addr_q  <= disc_addr_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc2_q   <= ifid_pc2_d;
      req_en_q     <= 1'b1;
    end
  end
  assign ifid_valid    = ifid_valid_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_pc_plus2 = ifid_pc2_q;
  assign halted        = state_q == HALTED;
endmodule
